// File: rtl/configurable_mult_pipe.sv
// configurable_mult_pipe
//
// Pipelined WIDTH x WIDTH multiplier with independent signed/unsigned selection per
// operand, so mixed-sign products are exact. A fixed number of register stages
// separates input acceptance from the result. An opaque tag travels with each
// transaction. Flow control is a single global advance: every stage moves together.
// Bubbles keep their slot and are never collapsed.
//
// Parameters:
//   WIDTH       operand width (>= 2)
//   STAGES      register stages from acceptance to output (>= 1)
//   TAG_W       pass-through tag width (>= 1)
//   SIGNED_MODE when 1, both operands are treated as signed
//
// Ports:
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   in_valid    input transaction present
//   in_ready    block can accept (combinational from out_valid/out_ready)
//   a, b        operands
//   a_signed    operand A is two's complement (ORed with SIGNED_MODE)
//   b_signed    operand B is two's complement (ORed with SIGNED_MODE)
//   in_tag      user tag, returned unchanged with the result
//   out_valid   result present
//   out_ready   downstream accepts the result
//   product     2*WIDTH-bit result
//   out_tag     tag of the result
//   out_signed  result is two's complement
//   busy        any stage holds a valid transaction

module configurable_mult_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned STAGES      = 3,
    parameter int unsigned TAG_W       = 4,
    parameter bit          SIGNED_MODE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 a_signed,
    input  logic                 b_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_signed,
    output logic                 busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned FW = 2 * WIDTH + 2;

    // Effective sign flags and operand extension.
    logic                 sa;
    logic                 sb;
    logic [WIDTH:0]       a_ext;
    logic [WIDTH:0]       b_ext;
    logic signed [FW-1:0] a_wide;
    logic signed [FW-1:0] b_wide;
    logic signed [FW-1:0] full_prod;
    logic [PW-1:0]        mul_res;
    logic                 res_signed;
    logic                 adv;

    // Per-stage state; index STAGES-1 is the output stage.
    logic [STAGES-1:0]    valid_q;
    logic [PW-1:0]        prod_q [STAGES];
    logic [TAG_W-1:0]     tag_q  [STAGES];
    logic [STAGES-1:0]    sgn_q;

    always_comb begin
        sa         = SIGNED_MODE | a_signed;
        sb         = SIGNED_MODE | b_signed;
        // Extra top bit is the sign for signed operands and zero otherwise, so an
        // unsigned operand stays non-negative inside the signed multiply.
        a_ext      = {sa & a[WIDTH-1], a};
        b_ext      = {sb & b[WIDTH-1], b};
        a_wide     = {{(WIDTH + 1){a_ext[WIDTH]}}, a_ext};
        b_wide     = {{(WIDTH + 1){b_ext[WIDTH]}}, b_ext};
        full_prod  = a_wide * b_wide;
        // Every sign combination fits in 2*WIDTH bits, so truncation is exact.
        mul_res    = full_prod[PW-1:0];
        res_signed = sa | sb;
    end

    // One advance signal for the whole pipe: move whenever the output slot is
    // empty or being consumed.
    assign adv      = ~valid_q[STAGES-1] | out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            sgn_q   <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                prod_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (adv) begin
            // Stage 0 always loads; an idle input enters as a bubble.
            valid_q[0] <= in_valid;
            prod_q[0]  <= mul_res;
            tag_q[0]   <= in_tag;
            sgn_q[0]   <= res_signed;
            for (int unsigned i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                prod_q[i]  <= prod_q[i-1];
                tag_q[i]   <= tag_q[i-1];
                sgn_q[i]   <= sgn_q[i-1];
            end
        end
    end

    assign out_valid  = valid_q[STAGES-1];
    assign product    = prod_q[STAGES-1];
    assign out_tag    = tag_q[STAGES-1];
    assign out_signed = sgn_q[STAGES-1];
    assign busy       = |valid_q;

endmodule

// File: tb/tb_configurable_mult_pipe.sv
module tb_configurable_mult_pipe;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 3;
    localparam int unsigned TAG_W  = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             a_signed;
    logic             b_signed;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    // Instance 0: SIGNED_MODE=0, instance 1: SIGNED_MODE=1, same stimulus.
    logic               in_ready0, in_ready1;
    logic               out_valid0, out_valid1;
    logic [2*WIDTH-1:0] product0, product1;
    logic [TAG_W-1:0]   out_tag0, out_tag1;
    logic               out_signed0, out_signed1;
    logic               busy0, busy1;

    configurable_mult_pipe #(
        .WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W), .SIGNED_MODE(1'b0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .in_tag(in_tag),
        .out_valid(out_valid0), .out_ready(out_ready), .product(product0),
        .out_tag(out_tag0), .out_signed(out_signed0), .busy(busy0)
    );

    configurable_mult_pipe #(
        .WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W), .SIGNED_MODE(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .in_tag(in_tag),
        .out_valid(out_valid1), .out_ready(out_ready), .product(product1),
        .out_tag(out_tag1), .out_signed(out_signed1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: a transaction is a queue entry that reaches the output
    // after STAGES advances of the pipe, counted from the advance that accepted it.
    typedef struct {
        logic [15:0] p0;
        logic [15:0] p1;
        logic        s0;
        logic        s1;
        logic [3:0]  tag;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          adv_cnt = 0;
    logic [15:0] last_p0, last_p1;
    logic        last_s0, last_s1;

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                            input bit sx, input bit sy);
        int xv, yv, pv;
        xv = sx ? int'($signed(x)) : int'({24'd0, x});
        yv = sy ? int'($signed(y)) : int'({24'd0, y});
        pv = xv * yv;
        return pv[15:0];
    endfunction

    // One clock cycle: drive at posedge+1, check at negedge, update model at posedge.
    task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv,
                        input logic as_, input logic bs_, input logic [3:0] tg,
                        input logic ordy);
        logic exp_ov;
        exp_t e;
        in_valid  = v;
        a         = av;
        b         = bv;
        a_signed  = as_;
        b_signed  = bs_;
        in_tag    = tg;
        out_ready = ordy;
        @(negedge clk);
        exp_ov = (q.size() != 0) && (q[0].due == adv_cnt);
        check("out_valid0", 32'(out_valid0), 32'(exp_ov));
        check("out_valid1", 32'(out_valid1), 32'(exp_ov));
        check("in_ready0", 32'(in_ready0), 32'(!exp_ov || ordy));
        check("in_ready1", 32'(in_ready1), 32'(!exp_ov || ordy));
        check("busy0", 32'(busy0), 32'(q.size() != 0));
        check("busy1", 32'(busy1), 32'(q.size() != 0));
        if (exp_ov) begin
            check("product0", 32'(product0), 32'(q[0].p0));
            check("product1", 32'(product1), 32'(q[0].p1));
            check("out_signed0", 32'(out_signed0), 32'(q[0].s0));
            check("out_signed1", 32'(out_signed1), 32'(q[0].s1));
            check("out_tag0", 32'(out_tag0), 32'(q[0].tag));
            check("out_tag1", 32'(out_tag1), 32'(q[0].tag));
            last_p0 = product0;
            last_p1 = product1;
            last_s0 = out_signed0;
            last_s1 = out_signed1;
        end
        @(posedge clk);
        if (!exp_ov || ordy) begin
            adv_cnt++;
            if (exp_ov) void'(q.pop_front());
            if (v) begin
                e.p0  = ref_mul(av, bv, as_, bs_);
                e.p1  = ref_mul(av, bv, 1'b1, 1'b1);
                e.s0  = as_ | bs_;
                e.s1  = 1'b1;
                e.tag = tg;
                e.due = adv_cnt + STAGES - 1;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        last_p0 = '0; last_p1 = '0; last_s0 = 1'b0; last_s1 = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_product", 32'(product0), 32'd0);
        check("rst_out_tag", 32'(out_tag0), 32'd0);
        check("rst_out_signed", 32'(out_signed0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_in_ready", 32'(in_ready0), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // u x u max; signed-mode instance sees -1 x -1.
        step(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 4'h1, 1'b1);
        idle(STAGES);
        check("uu_255x255", 32'(last_p0), 32'h0000FE01);
        check("uu_out_signed", 32'(last_s0), 32'd0);

        // s x u: -128 * 255.
        step(1'b1, 8'h80, 8'hFF, 1'b1, 1'b0, 4'h2, 1'b1);
        idle(STAGES);
        check("su_m128x255", 32'(last_p0), 32'h00008080);
        check("su_out_signed", 32'(last_s0), 32'd1);

        // s x s: -128 * -1.
        step(1'b1, 8'h80, 8'hFF, 1'b1, 1'b1, 4'h3, 1'b1);
        idle(STAGES);
        check("ss_m128xm1", 32'(last_p0), 32'h00000080);

        // Signed-mode instance forces 0xFF as -1: -1 * 2.
        step(1'b1, 8'hFF, 8'h02, 1'b0, 1'b0, 4'h4, 1'b1);
        idle(STAGES);
        check("smode_m1x2", 32'(last_p1), 32'h0000FFFE);
        check("smode_out_signed", 32'(last_s1), 32'd1);
        check("nosmode_255x2", 32'(last_p0), 32'h000001FE);

        // Back-to-back stream, tags 0..7.
        for (int i = 0; i < 8; i++)
            step(1'b1, 8'(i * 17 + 3), 8'(i * 29 + 1), 1'b0, 1'(i % 2), 4'(i), 1'b1);
        idle(STAGES);

        // Backpressure mid-stream for 4 cycles with input still offered.
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'(i + 10), 8'(i + 20), 1'b1, 1'b0, 4'(i + 8), 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'hAA, 8'h55, 1'b1, 1'b1, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'(i + 30), 8'(i + 40), 1'b0, 1'b1, 4'(i + 12), 1'b1);
        idle(STAGES + 1);

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'(i + 7), 8'(i + 9), 1'b0, 1'b0, 4'(i + 5), 1'b1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid0), 32'd0);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_product", 32'(product0), 32'd0);
        check("midrst_in_ready", 32'(in_ready0), 32'd1);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 8'd3, 8'd5, 1'b0, 1'b0, 4'h9, 1'b1);
        idle(STAGES);
        check("post_rst_3x5", 32'(last_p0), 32'd15);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), 4'($urandom),
                 1'($urandom_range(0, 9) < 7));
        idle(STAGES + 2);
        check("drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
